// File: rtl/bram_mailbox_writer.sv
// Moves FIFO words into BRAM mailbox slots, re-polling a slot's full flag until the consumer frees it.
// Latency fifo_ready->bram_wea is BRAM_LAT+4; a full slot blocks without popping, stall flags POLL_MAX polls.
module bram_mailbox_writer #(
  parameter int DATA_W   = 8,
  parameter int SLOT_AW  = 2,
  parameter int BRAM_LAT = 1,
  parameter int POLL_MAX = 16
) (
  input  logic               clk_25mhz,
  input  logic               rst_n,
  input  logic               fifo_ready,
  input  logic [DATA_W-1:0]  fifo_din,
  output logic               rd_en,
  input  logic [DATA_W:0]    bram_douta,
  output logic [SLOT_AW-1:0] bram_addra,
  output logic [DATA_W:0]    bram_dina,
  output logic               bram_wea,
  output logic               busy,
  output logic               stall,
  output logic [15:0]        wr_count
);
  localparam int LAT_W  = 2;
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(BRAM_LAT - 1);
  localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(POLL_MAX);

  typedef enum logic [2:0] {IDLE, WAIT, CHECK, POP, CAP, WR} state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [POLL_W-1:0] poll_cnt;
  logic [POLL_W-1:0] poll_inc;
  logic [DATA_W-1:0] data_reg;
  logic              dina_flag;
  logic              unused_payload;

  // Only the full flag of the read word matters; payload belongs to the consumer.
  assign unused_payload = ^bram_douta[DATA_W:1];

  assign poll_inc  = (poll_cnt >= POLL_LIM) ? poll_cnt : poll_cnt + POLL_W'(1);
  assign rd_en     = (state == POP);
  assign bram_wea  = (state == WR);
  assign bram_dina = {data_reg, dina_flag};

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      poll_cnt   <= '0;
      data_reg   <= '0;
      dina_flag  <= 1'b0;
      bram_addra <= '0;
      busy       <= 1'b0;
      stall      <= 1'b0;
      wr_count   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_ready) begin
            state   <= WAIT;
            lat_cnt <= LAT_LOAD;
            busy    <= 1'b1;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) state <= CHECK;
          else               lat_cnt <= lat_cnt - LAT_W'(1);
        end
        CHECK: begin
          if (bram_douta[0]) begin
            // Slot still owned by the consumer: re-read it after another BRAM latency.
            poll_cnt <= poll_inc;
            stall    <= (poll_inc >= POLL_LIM);
            lat_cnt  <= LAT_LOAD;
            state    <= WAIT;
          end else begin
            poll_cnt <= '0;
            stall    <= 1'b0;
            if (fifo_ready) begin
              state <= POP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        POP: state <= CAP;
        CAP: begin
          data_reg  <= fifo_din;
          dina_flag <= 1'b1;
          state     <= WR;
        end
        WR: begin
          bram_addra <= bram_addra + SLOT_AW'(1);
          wr_count   <= wr_count + 16'd1;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bram_mailbox_writer.sv
// Bench for bram_mailbox_writer: cycle table, directed corner sequences, random FIFO/BRAM traffic.
`timescale 1ns/1ps
module tb_bram_mailbox_writer;
  logic clk = 1'b0;
  always #20 clk = ~clk;

  // Default-parameter instance
  logic        rst_n, fifo_ready, rd_en, wea, busy, stall;
  logic [7:0]  fifo_din;
  logic [8:0]  douta, dina;
  logic [1:0]  addra;
  logic [15:0] wr_count;

  bram_mailbox_writer dut (
    .clk_25mhz(clk), .rst_n(rst_n), .fifo_ready(fifo_ready), .fifo_din(fifo_din),
    .rd_en(rd_en), .bram_douta(douta), .bram_addra(addra), .bram_dina(dina),
    .bram_wea(wea), .busy(busy), .stall(stall), .wr_count(wr_count)
  );

  // Wide, deeper, slower-BRAM instance
  logic        rst2_n, fr2, rd2, wea2, busy2, stall2;
  logic [11:0] din2;
  logic [12:0] douta2, dina2;
  logic [2:0]  addra2;
  logic [15:0] wr_count2;

  bram_mailbox_writer #(.DATA_W(12), .SLOT_AW(3), .BRAM_LAT(2), .POLL_MAX(16)) dut2 (
    .clk_25mhz(clk), .rst_n(rst2_n), .fifo_ready(fr2), .fifo_din(din2),
    .rd_en(rd2), .bram_douta(douta2), .bram_addra(addra2), .bram_dina(dina2),
    .bram_wea(wea2), .busy(busy2), .stall(stall2), .wr_count(wr_count2)
  );

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic        fr;
    logic        full;
    logic [7:0]  din;
    logic        e_rd;
    logic        e_wea;
    logic        e_busy;
    logic [1:0]  e_addr;
    logic [8:0]  e_dina;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[20];

  // Random-test model state
  logic [7:0] q[$];
  logic [7:0] popped[$];
  logic       mem_flag[4];
  logic [7:0] mem_data[4];
  logic [1:0] hist[5];
  logic [7:0] cap_word, exp_w;
  logic       in_cap, in_cap_now;
  int         slot_exp, nwr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; fifo_ready = 1'b0; fifo_din = 8'h00; douta = 9'h000;
    tick(); tick();
    check("rst_rd_en", rd_en, 0);
    check("rst_wea", wea, 0);
    check("rst_addra", addra, 0);
    check("rst_dina", dina, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_wr_count", wr_count, 0);
    rst_n = 1'b1;
  endtask

  // Carries one word through with an empty slot; returns the address/data seen at the write.
  task automatic xfer_word(input logic [7:0] w, output logic [1:0] a, output logic [8:0] d);
    logic got, cap;
    got = 1'b0; cap = 1'b0; a = '0; d = '0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      fifo_din = cap ? w : 8'h00;
      cap = rd_en;
      if (wea) begin
        got = 1'b1; a = addra; d = dina;
      end
    end
    check("xfer_done", got, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] a;
    logic [8:0] d;
    logic [7:0] wb;
    logic       seen, got;
    int         first, nw;

    rst2_n = 1'b0; fr2 = 1'b0; din2 = '0; douta2 = '0;

    //              fr    full  din    rd    wea   busy  addr  dina    cnt
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 9'h000, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 2'd0, 9'h000, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 2'd0, 9'h000, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 2'd0, 9'h000, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 2'd0, 9'h000, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 2'd0, 9'h155, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 2'd1, 9'h000, 16'd1};
    tbl[7]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 2'd1, 9'h000, 16'd1};
    tbl[8]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 2'd1, 9'h000, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 2'd1, 9'h000, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 2'd1, 9'h000, 16'd1};
    tbl[11] = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 2'd1, 9'h000, 16'd1};
    tbl[12] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 2'd1, 9'h000, 16'd1};
    tbl[13] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 2'd1, 9'h000, 16'd1};
    tbl[14] = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 2'd1, 9'h000, 16'd1};
    tbl[15] = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 2'd1, 9'h000, 16'd1};
    tbl[16] = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 2'd1, 9'h000, 16'd1};
    tbl[17] = '{1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 2'd1, 9'h000, 16'd1};
    tbl[18] = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 2'd1, 9'h0B5, 16'd1};
    tbl[19] = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 2'd2, 9'h000, 16'd2};

    // Cycle table: outputs of cycle i are checked, then inputs for cycle i driven.
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("tbl%0d_rd_en", i), rd_en, tbl[i].e_rd);
      check($sformatf("tbl%0d_wea", i), wea, tbl[i].e_wea);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_addra", i), addra, tbl[i].e_addr);
      check($sformatf("tbl%0d_wr_count", i), wr_count, tbl[i].e_cnt);
      check($sformatf("tbl%0d_stall", i), stall, 0);
      if (tbl[i].e_wea) check($sformatf("tbl%0d_dina", i), dina, tbl[i].e_dina);
      fifo_ready = tbl[i].fr;
      douta      = {8'h00, tbl[i].full};
      fifo_din   = tbl[i].din;
      tick();
    end

    // Five words into four empty slots: sequential addresses, then wrap to 0.
    reset_dut();
    fifo_ready = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      wb = 8'(w);
      xfer_word(wb, a, d);
      check($sformatf("wrap_addr_w%0d", w), a, (w - 1) % 4);
      check($sformatf("wrap_dina_w%0d", w), d, {wb, 1'b1});
    end
    fifo_ready = 1'b0;
    tick(); tick();
    check("wrap_wr_count", wr_count, 5);

    // Slot full for 20 polls: CHECK falls on even cycles, stall follows the 16th poll.
    reset_dut();
    fifo_ready = 1'b1; douta = 9'h001;
    seen = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      tick();
      if (c < 43) seen = seen | rd_en;
      if (c == 32) check("stall_before_16th", stall, 0);
      if (c == 33) check("stall_after_16th", stall, 1);
      if (c == 42) check("stall_held", stall, 1);
      if (c == 43) begin
        check("stall_cleared", stall, 0);
        check("stall_pop", rd_en, 1);
      end
      if (c == 45) begin
        check("stall_wea", wea, 1);
        check("stall_dina", dina, 9'h0EF);
        check("stall_addr", addra, 0);
      end
      douta    = (c <= 40) ? 9'h001 : 9'h000;
      fifo_din = (c == 44) ? 8'h77 : 8'h00;
    end
    check("stall_no_pop_while_full", seen, 0);
    fifo_ready = 1'b0;

    // Reset pulse during CAP aborts the word; pointer restarts at slot 0.
    reset_dut();
    fifo_ready = 1'b1;
    xfer_word(8'h11, a, d);
    check("rstcap_first_addr", a, 0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      fifo_din = 8'h00;
      got = rd_en;
    end
    check("rstcap_pop_seen", got, 1);
    tick();
    fifo_din = 8'h99;
    #1 rst_n = 1'b0;
    #1;
    check("rstcap_busy", busy, 0);
    check("rstcap_wea", wea, 0);
    check("rstcap_rd_en", rd_en, 0);
    check("rstcap_addra", addra, 0);
    check("rstcap_dina", dina, 0);
    check("rstcap_wr_count", wr_count, 0);
    fifo_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | wea | rd_en;
    end
    check("rstcap_no_activity", seen, 0);
    fifo_ready = 1'b1;
    xfer_word(8'h42, a, d);
    check("rstcap_next_addr", a, 0);
    check("rstcap_next_dina", d, 9'h085);
    fifo_ready = 1'b0;
    tick();
    check("rstcap_next_count", wr_count, 1);

    // Random traffic against an ordered-FIFO / sequential-slot mailbox model.
    reset_dut();
    q.delete(); popped.delete();
    for (int s = 0; s < 4; s++) begin mem_flag[s] = 1'b0; mem_data[s] = 8'h00; end
    for (int s = 0; s < 5; s++) hist[s] = 2'd0;
    slot_exp = 0; nwr = 0; in_cap = 1'b0; cap_word = 8'h00;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      tick();
      if (cyc >= 2000 && q.size() == 0 && popped.size() == 0 && !busy) break;
      check("rnd_no_overlap", rd_en & wea, 0);
      if (wea) begin
        check("rnd_wr_count", wr_count, 16'(nwr));
        check("rnd_pending_word", popped.size() > 0, 1);
        exp_w = (popped.size() > 0) ? popped.pop_front() : 8'h00;
        check("rnd_addr", addra, slot_exp);
        check("rnd_dina", dina, {exp_w, 1'b1});
        check("rnd_slot_was_free", mem_flag[addra], 0);
        mem_flag[addra] = 1'b1;
        mem_data[addra] = dina[8:1];
        slot_exp = (slot_exp + 1) % 4;
        nwr++;
      end
      in_cap_now = in_cap;
      in_cap = 1'b0;
      if (rd_en) begin
        check("rnd_fifo_nonempty", q.size() > 0, 1);
        cap_word = (q.size() > 0) ? q.pop_front() : 8'h00;
        popped.push_back(cap_word);
        in_cap = 1'b1;
      end
      fifo_din = in_cap_now ? cap_word : 8'($urandom);
      if (cyc < 2000 && $urandom_range(0, 11) == 0) q.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0) mem_flag[$urandom_range(0, 3)] = 1'b0;
      fifo_ready = (q.size() != 0);
      for (int s = 4; s > 0; s--) hist[s] = hist[s-1];
      hist[0] = addra;
      douta = {mem_data[hist[1]], mem_flag[hist[1]]};
    end
    check("rnd_drained", q.size() + popped.size(), 0);
    check("rnd_final_count", wr_count, 16'(nwr));
    fifo_ready = 1'b0;

    // Wide instance: 12-bit payload, 8 slots, 2-cycle BRAM.
    tick();
    rst2_n = 1'b1; fr2 = 1'b1; douta2 = '0; din2 = 12'hABC;
    first = -1; nw = 0;
    for (int c = 1; c <= 100 && nw < 9; c++) begin
      tick();
      if (wea2) begin
        if (nw == 0) first = c;
        check($sformatf("p2_dina_%0d", nw), dina2, 13'h1579);
        check($sformatf("p2_addr_%0d", nw), addra2, nw % 8);
        nw++;
      end
    end
    check("p2_first_wea_cycle", first, 6);
    check("p2_write_count", nw, 9);
    fr2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bram_mailbox_writer.md
BRAM_MAILBOX_WRITER -- requirements
Module: bram_mailbox_writer

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 Parameter SLOT_AW, default 2, slot address width; 2**SLOT_AW mailbox slots.
REQ-003 Parameter BRAM_LAT, default 1, BRAM read latency in cycles, legal range 1..4.
REQ-004 Parameter POLL_MAX, default 16, consecutive full-slot polls before stall asserts, legal range >=1.
REQ-005 clk_25mhz  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 fifo_ready  in  1  high = source FIFO holds at least one word.
REQ-008 fifo_din  in  DATA_W  FIFO read data, valid the cycle after rd_en.
REQ-009 rd_en  out  1  FIFO pop strobe, one cycle per word.
REQ-010 bram_douta  in  DATA_W+1  BRAM port-A read data; bit 0 = slot-full flag, bits [DATA_W:1] = payload.
REQ-011 bram_addra  out  SLOT_AW  current slot address, read and write.
REQ-012 bram_dina  out  DATA_W+1  write data {payload, 1'b1}.
REQ-013 bram_wea  out  1  BRAM write enable, one cycle per word.
REQ-014 busy  out  1  high whenever FSM is not IDLE.
REQ-015 stall  out  1  high while consecutive full-slot polls on current slot >= POLL_MAX.
REQ-016 wr_count  out  16  total words written, wraps 16'hFFFF -> 0.

Function
REQ-017 All outputs shall be registered, except rd_en and bram_wea, which shall be decoded from the registered FSM state.
REQ-018 FSM states shall be IDLE, WAIT, CHECK, POP, CAP, WR.
REQ-019 IDLE: if fifo_ready=1, go to WAIT and load lat_cnt=BRAM_LAT-1; otherwise stay in IDLE.
REQ-020 WAIT: if lat_cnt=0, go to CHECK; otherwise decrement lat_cnt. bram_addra shall stay at the slot pointer throughout.
REQ-021 CHECK, bram_douta[0]=0 and fifo_ready=1: go to POP and clear poll_cnt.
REQ-022 CHECK, bram_douta[0]=1: increment poll_cnt, saturating at POLL_MAX; reload lat_cnt; return to WAIT to re-read the slot.
REQ-023 CHECK, bram_douta[0]=0 and fifo_ready=0: return to IDLE with no pop.
REQ-024 POP: rd_en=1 for exactly this cycle; go to CAP unconditionally.
REQ-025 CAP: latch fifo_din into the data register; go to WR.
REQ-026 WR: bram_wea=1 and bram_dina={data_reg,1'b1} at the current address. On exit: slot pointer +1 mod 2**SLOT_AW, wr_count +1, return to IDLE.
REQ-027 Once POP is entered, CAP and WR shall complete regardless of fifo_ready.
REQ-028 stall shall be 1 exactly when poll_cnt >= POLL_MAX. It shall clear on the cycle after the CHECK that sees a free slot.
REQ-029 Minimum word latency: fifo_ready high in IDLE to bram_wea high = BRAM_LAT+4 cycles.
REQ-030 Slot pointer wrap: after the write to slot 2**SLOT_AW-1, the next access shall target slot 0.
REQ-031 Every BRAM write shall set flag=1. The block shall never clear a flag; the consumer clears flags.
REQ-032 At most one rd_en and one bram_wea per word. rd_en and bram_wea shall never be high in the same cycle.

Reset
REQ-033 On rst_n=0, asynchronously: state=IDLE; rd_en=0, bram_wea=0, bram_addra=0, bram_dina=0; busy=0, stall=0, wr_count=0; poll_cnt=0, lat_cnt=0, data_reg=0.
REQ-034 Reset during POP/CAP/WR shall abort the word with no BRAM write. The popped FIFO word is lost; this is accepted.
REQ-035 After rst_n deasserts, the first action shall occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-036 Defaults, fifo_ready=1 from IDLE, douta=9'h000, fifo_din=8'hAA: rd_en pulse at cycle 3, wea at cycle 5, dina=9'h155, addra=0, wr_count=1.
REQ-037 Four consecutive words 8'h01..8'h04 with all slots empty: writes to addra 0,1,2,3; the fifth word goes to addra 0 (wrap); wr_count=5.
REQ-038 douta[0]=1 held 20 polls then released, POLL_MAX=16: no rd_en while full; stall rises on the 16th poll and clears after the first free CHECK; the word is then written.
REQ-039 fifo_ready drops while in WAIT, slot empty: CHECK returns to IDLE; no rd_en, no wea; busy falls.
REQ-040 rst_n pulsed low during CAP: outputs go to reset values immediately; no wea occurs; next word targets addra 0.
REQ-041 DATA_W=12, SLOT_AW=3, BRAM_LAT=2, fifo_din=12'hABC: dina=13'h1579, wea at cycle 6; nine writes wrap addra 0..7 then 0.
